encoder_16_4_rr: RTL

- Registered 16-to-4 round-robin encoder. It is the encode-direction counterpart of the team's 4-to-16 decoder and 1-to-4 demux.
- Takes a multi-hot request vector and selects one active line with rotating priority.
- Presents the selected line's index and one-hot code on a valid/ready output interface.
- Returns a one-cycle acknowledge to the granted source. It sits upstream of the decoder/demux path, so that decoded index can steer the channel back out.

---
 rtl/encoder_pkg.sv | 21 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/encoder_16_4_rr.sv | 131 +++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types, sizes and helpers for the round-robin encoder
// Purpose: default sizes, FSM state type and index-to-one-hot helper.
// Ports: none (package).
package encoder_pkg;

  localparam int N_DEFAULT = 16;
  localparam int W_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_DEFAULT-1:0] idx_to_onehot(input logic [W_DEFAULT-1:0] idx);
    logic [N_DEFAULT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority winner select
// Purpose: pick the lowest candidate at or above ptr, else wrap to the lowest below ptr.
// Ports:
//   cand   in  N  candidate lines
//   ptr    in  W  priority pointer (highest-priority position)
//   any    out 1  at least one candidate present
//   idx    out W  winning index (don't-care when any=0)
//   onehot out N  one-hot of idx, zero when any=0
module rr_pick
  import encoder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  logic [2*N-1:0]       w_dbl;
  logic                 w_found;
  logic [W-1:0]         w_idx;
  logic [W_DEFAULT-1:0] w_idx_ext;
  logic [N_DEFAULT-1:0] w_oh_full;

  // Scanning {cand,cand} from ptr upward covers the wrap case without a
  // second priority chain: bits below ptr in the upper copy are the wrapped
  // candidates. Position k maps back to index k mod N (N is a power of two).
  always_comb begin
    w_dbl   = {cand, cand};
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (!w_found && w_dbl[k] && (k >= int'(ptr))) begin
        w_found = 1'b1;
        w_idx   = W'(k);
      end
    end
  end

  assign w_idx_ext = W_DEFAULT'(w_idx);
  assign w_oh_full = idx_to_onehot(w_idx_ext);

  assign any    = |cand;
  assign idx    = w_idx;
  assign onehot = any ? w_oh_full[N-1:0] : '0;

endmodule

// File: rtl/encoder_16_4_rr.sv
// rtl/encoder_16_4_rr.sv - registered 16-to-4 round-robin encoder with valid/ready and ack
// Purpose: commit one requester per grant with rotating priority, hold it until
//          accepted, and pulse ack back to the granted source on the handshake.
// Ports:
//   clk        in  1  system clock, rising edge
//   rst        in  1  asynchronous reset, active-high
//   req        in  N  level-sensitive request lines, bit i = source i
//   out_ready  in  1  downstream accepts the current grant
//   out_valid  out 1  a grant is committed
//   out_idx    out W  binary index of the granted line
//   out_onehot out N  one-hot of out_idx, zero when not valid
//   ack        out N  one-hot pulse on the handshake cycle
module encoder_16_4_rr
  import encoder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] ack
);

  state_t       r_state;
  logic [W-1:0] r_ptr;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;

  state_t       w_nxt_state;
  logic [W-1:0] w_nxt_ptr;
  logic         w_nxt_valid;
  logic [W-1:0] w_nxt_idx;
  logic [N-1:0] w_nxt_onehot;

  logic         w_hs;
  logic [W-1:0] w_ptr_adv;
  logic [N-1:0] w_cand;
  logic [W-1:0] w_pick_ptr;
  logic         w_any;
  logic [W-1:0] w_win_idx;
  logic [N-1:0] w_win_onehot;

  assign w_hs      = r_valid & out_ready;
  // W-bit add wraps N-1 back to 0.
  assign w_ptr_adv = r_idx + W'(1);

  // In HOLD the picker only matters on a handshake, where the just-granted
  // line is excluded and priority starts right after it (the updated ptr).
  assign w_cand     = (r_state == HOLD) ? (req & ~r_onehot) : req;
  assign w_pick_ptr = (r_state == HOLD) ? w_ptr_adv : r_ptr;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .cand   (w_cand),
    .ptr    (w_pick_ptr),
    .any    (w_any),
    .idx    (w_win_idx),
    .onehot (w_win_onehot)
  );

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_ptr    = r_ptr;
    w_nxt_valid  = r_valid;
    w_nxt_idx    = r_idx;
    w_nxt_onehot = r_onehot;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nxt_state  = HOLD;
          w_nxt_valid  = 1'b1;
          w_nxt_idx    = w_win_idx;
          w_nxt_onehot = w_win_onehot;
        end
      end
      HOLD: begin
        // Without a handshake everything is held: a committed grant is
        // never withdrawn, whatever req does.
        if (w_hs) begin
          w_nxt_ptr = w_ptr_adv;
          if (w_any) begin
            w_nxt_idx    = w_win_idx;
            w_nxt_onehot = w_win_onehot;
          end else begin
            w_nxt_state  = IDLE;
            w_nxt_valid  = 1'b0;
            w_nxt_idx    = '0;
            w_nxt_onehot = '0;
          end
        end
      end
      default: begin
        w_nxt_state  = IDLE;
        w_nxt_valid  = 1'b0;
        w_nxt_idx    = '0;
        w_nxt_onehot = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_ptr    <= w_nxt_ptr;
      r_valid  <= w_nxt_valid;
      r_idx    <= w_nxt_idx;
      r_onehot <= w_nxt_onehot;
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  // Driven from registered state, so reset clears it without a clock edge.
  assign ack        = w_hs ? r_onehot : '0;

endmodule
